// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding and bit-slot phase constants for the I2C master
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    WRITE,
    READ,
    DATA_ACK,
    MACK,
    STOP
  } state_t;

  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;
  localparam logic [1:0] P3 = 2'd3;

  localparam int BITS_PER_BYTE = 8;

endpackage

// File: rtl/i2c_clk_gen.sv
// rtl/i2c_clk_gen.sv - phase tick every CLK_DIV clocks and 2-bit slot phase; held at zero when disabled
module i2c_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       stall,
  output logic       phase_tick,
  output logic [1:0] phase
);

  localparam logic [15:0] CNT_MAX = 16'(CLK_DIV - 1);

  logic [15:0] cnt_q;

  assign phase_tick = enable && !stall && (cnt_q == CNT_MAX);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      phase <= '0;
    end else if (!enable) begin
      cnt_q <= '0;
      phase <= '0;
    end else if (!stall) begin
      if (cnt_q == CNT_MAX) begin
        cnt_q <= '0;
        phase <= phase + 2'd1;
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: rtl/i2c_master.sv
// rtl/i2c_master.sv - single-byte I2C master (START, addr+R/W, ACK, byte, ACK/NACK, STOP)
// Define I2C_CLK_STRETCH_EN to let a slave hold SCL low during p2.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  inout  wire        i2c_scl_inout,
  inout  wire        i2c_sda_inout,
  input  logic [6:0] addr,
  input  logic [7:0] data,
  input  logic       read_write,
  input  logic       start,
  output logic       ready_out,
  output logic [7:0] rd_data_out,
  output logic       ack_err_out
);

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  tx_q, rx_q, data_q;
  logic        rw_q, ack_q;
  logic [1:0]  sda_sync_q;
  logic        scl_low, sda_low, stall;
  logic        phase_tick, sample_pt, last_slot, last_bit;
  logic [1:0]  phase;

  assign i2c_scl_inout = scl_low ? 1'b0 : 1'bz;
  assign i2c_sda_inout = sda_low ? 1'b0 : 1'bz;

`ifdef I2C_CLK_STRETCH_EN
  logic [1:0] scl_sync_q;
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) scl_sync_q <= 2'b11;
    else         scl_sync_q <= {scl_sync_q[0], i2c_scl_inout};
  end
  assign stall = (phase == P2) && !scl_sync_q[1];
`else
  assign stall = 1'b0;
`endif

  i2c_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk_in     (clk_in),
    .rst_n      (rst_in),
    .enable     (state_q != IDLE),
    .stall      (stall),
    .phase_tick (phase_tick),
    .phase      (phase)
  );

  assign sample_pt = phase_tick && (phase == P2);
  assign last_slot = phase_tick && (phase == P3);
  assign last_bit  = bit_cnt_q == 3'(BITS_PER_BYTE - 1);
  assign ready_out = state_q == IDLE;

  always_comb begin
    state_d = state_q;
    scl_low = 1'b0;
    sda_low = 1'b0;
    case (state_q)
      IDLE:     if (start) state_d = START;
      START: begin
        sda_low = phase[1];
        if (last_slot) state_d = ADDR;
      end
      ADDR: begin
        scl_low = !phase[1];
        sda_low = !tx_q[7];
        if (last_slot && last_bit) state_d = ADDR_ACK;
      end
      ADDR_ACK: begin
        scl_low = !phase[1];
        if (last_slot) state_d = ack_q ? STOP : (rw_q ? READ : WRITE);
      end
      WRITE: begin
        scl_low = !phase[1];
        sda_low = !tx_q[7];
        if (last_slot && last_bit) state_d = DATA_ACK;
      end
      DATA_ACK: begin
        scl_low = !phase[1];
        if (last_slot) state_d = STOP;
      end
      READ: begin
        scl_low = !phase[1];
        if (last_slot && last_bit) state_d = MACK;
      end
      MACK: begin
        scl_low = !phase[1];
        if (last_slot) state_d = STOP;
      end
      STOP: begin
        scl_low = !phase[1];
        sda_low = phase != P3;
        if (last_slot) state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      data_q      <= '0;
      rw_q        <= 1'b0;
      ack_q       <= 1'b1;
      sda_sync_q  <= 2'b11;
      rd_data_out <= '0;
      ack_err_out <= 1'b0;
    end else begin
      state_q    <= state_d;
      sda_sync_q <= {sda_sync_q[0], i2c_sda_inout};
      if (state_q == IDLE && start) begin
        tx_q        <= {addr, read_write};
        data_q      <= data;
        rw_q        <= read_write;
        bit_cnt_q   <= '0;
        ack_err_out <= 1'b0;
      end
      if (sample_pt) begin
        ack_q <= sda_sync_q[1];
        if (state_q == READ) rx_q <= {rx_q[6:0], sda_sync_q[1]};
      end
      // bit counter wraps 7->0 by itself, so each byte state starts at zero
      if (last_slot) begin
        case (state_q)
          ADDR, WRITE: begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            tx_q      <= {tx_q[6:0], 1'b0};
          end
          READ:     bit_cnt_q <= bit_cnt_q + 3'd1;
          ADDR_ACK: begin
            if (ack_q) ack_err_out <= 1'b1;
            tx_q <= data_q;
          end
          DATA_ACK: if (ack_q) ack_err_out <= 1'b1;
          MACK:     rd_data_out <= rx_q;
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// tb/tb_i2c_master.sv - scoreboard bench for i2c_master with a bus monitor and simple slave model
`timescale 1ns/1ps
module tb_i2c_master;

  localparam int CLK_DIV = 4;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  wire        scl_w;
  wire        sda_w;
  logic [6:0] addr = '0;
  logic [7:0] data = '0;
  logic       read_write = 1'b0;
  logic       start = 1'b0;
  logic       ready_out;
  logic [7:0] rd_data_out;
  logic       ack_err_out;

  pullup(scl_w);
  pullup(sda_w);

  logic slave_sda_low = 1'b0;
  assign sda_w = slave_sda_low ? 1'b0 : 1'bz;

  i2c_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .i2c_scl_inout (scl_w),
    .i2c_sda_inout (sda_w),
    .addr          (addr),
    .data          (data),
    .read_write    (read_write),
    .start         (start),
    .ready_out     (ready_out),
    .rd_data_out   (rd_data_out),
    .ack_err_out   (ack_err_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] addr_byte;
    logic [7:0] data_byte;
    logic       ack2;
    int         nbits;
    logic       ack_err;
    logic [7:0] rd;
    int         lat;
    logic       full;
  } exp_t;

  exp_t exp_q[$];
  logic [7:0] exp_rd = 8'h00;

  // bus monitor and slave, sampled mid-cycle so simultaneous SCL/SDA moves are seen together
  logic       pscl = 1'b1, psda = 1'b1;
  int         bitn = 0, start_cnt = 0, stop_cnt = 0;
  logic [7:0] addr_sh = '0, data_sh = '0;
  logic       ack1 = 1'b1, ack2 = 1'b1;
  logic       slave_ack_en = 1'b1;
  logic [7:0] slave_byte = '0;

  always @(negedge clk_in) begin
    if (pscl && scl_w && psda && !sda_w) begin
      start_cnt++;
      bitn = 0;
    end else if (pscl && scl_w && !psda && sda_w) begin
      stop_cnt++;
    end else if (!pscl && scl_w) begin
      if (bitn < 8)       addr_sh = {addr_sh[6:0], sda_w};
      else if (bitn == 8) ack1 = sda_w;
      else if (bitn < 17) data_sh = {data_sh[6:0], sda_w};
      else if (bitn == 17) ack2 = sda_w;
      bitn++;
    end else if (pscl && !scl_w) begin
      slave_sda_low = 1'b0;
      if (slave_ack_en) begin
        if (bitn == 8) slave_sda_low = 1'b1;
        else if (addr_sh[0] && bitn >= 9 && bitn <= 16) slave_sda_low = !slave_byte[16-bitn];
        else if (!addr_sh[0] && bitn == 17) slave_sda_low = 1'b1;
      end
    end
    pscl = scl_w;
    psda = sda_w;
  end

  task automatic run_txn(input logic [6:0] a, input logic [7:0] d, input logic rw,
                         input logic ack_en, input logic [7:0] sbyte, input bit poke);
    exp_t e;
    int   cyc;
    int   s0, p0;
    e.addr_byte = {a, rw};
    e.ack_err   = !ack_en;
    e.full      = ack_en;
    e.nbits     = ack_en ? 19 : 10;
    e.data_byte = rw ? sbyte : d;
    e.ack2      = rw;
    e.lat       = (ack_en ? 20 : 11) * 4 * CLK_DIV;
    if (ack_en && rw) exp_rd = sbyte;
    e.rd = exp_rd;
    exp_q.push_back(e);

    slave_ack_en = ack_en;
    slave_byte   = sbyte;
    s0 = start_cnt;
    p0 = stop_cnt;
    @(negedge clk_in);
    addr = a; data = d; read_write = rw; start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    cyc = 0;
    while (!ready_out && cyc < 2000) begin
      if (poke && cyc == 40) begin
        start = 1'b1; addr = 7'h7F; read_write = 1'b1;
      end
      if (poke && cyc == 50) start = 1'b0;
      cyc++;
      @(negedge clk_in);
    end
    repeat (20) @(negedge clk_in);

    e = exp_q.pop_front();
    check("latency", cyc, e.lat);
    check("start_count", start_cnt - s0, 1);
    check("stop_count", stop_cnt - p0, 1);
    check("addr_byte", addr_sh, e.addr_byte);
    check("scl_rises", bitn, e.nbits);
    check("addr_ack", ack1, !ack_en);
    if (e.full) begin
      check("data_byte", data_sh, e.data_byte);
      check("data_ack", ack2, e.ack2);
    end
    check("ack_err", ack_err_out, e.ack_err);
    check("rd_data", rd_data_out, e.rd);
    check("ready_idle", ready_out, 1'b1);
    check("scl_released", scl_w, 1'b1);
    check("sda_released", sda_w, 1'b1);
  endtask

  initial begin
    int cyc;
    int s0;
    repeat (2) @(negedge clk_in);
    check("rst_scl", scl_w, 1'b1);
    check("rst_sda", sda_w, 1'b1);
    check("rst_ready", ready_out, 1'b1);
    check("rst_rd_data", rd_data_out, 8'h00);
    check("rst_ack_err", ack_err_out, 1'b0);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);

    run_txn(7'b1010101, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0);
    run_txn(7'h55,      8'h00, 1'b1, 1'b1, 8'hA5, 1'b0);
    run_txn(7'h33,      8'h5A, 1'b0, 1'b0, 8'h00, 1'b0);
    run_txn(7'h12,      8'h3C, 1'b0, 1'b1, 8'h00, 1'b1);

    slave_ack_en = 1'b1;
    s0 = start_cnt;
    @(negedge clk_in);
    addr = 7'h21; data = 8'h96; read_write = 1'b0; start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    cyc = 0;
    while (!(start_cnt != s0 && bitn == 12) && cyc < 3000) begin
      cyc++;
      @(negedge clk_in);
    end
    check("abort_reach_data", (start_cnt != s0 && bitn == 12), 1'b1);
    check("abort_busy", ready_out, 1'b0);
    rst_in = 1'b0;
    exp_rd = 8'h00;
    #1;
    check("abort_scl", scl_w, 1'b1);
    check("abort_sda", sda_w, 1'b1);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    check("abort_ready", ready_out, 1'b1);
    check("abort_rd_data", rd_data_out, 8'h00);
    check("abort_ack_err", ack_err_out, 1'b0);

    run_txn(7'h0F, 8'h81, 1'b1, 1'b1, 8'h3C, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
